// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the combinational instruction ROM and
// registers each fetched word into a one-entry valid/ready slot for decode.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; redirects only retarget the PC
// S_FETCH | fetching one word per cycle whenever the slot is free
// S_HALT  | all-zero word seen; only a redirect (or rst) resumes
module instr_fetch_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int RESET_PC     = 0,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              busy,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] L_PC_ONE   = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_instr;
    logic [ADDR_W-1:0]   r_out_pc;
    logic [15:0]         r_fetch_count;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_valid_nxt;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic [ADDR_W-1:0]   w_out_pc_nxt;
    logic [15:0]         w_count_nxt;

    logic                w_slot_free;
    logic                w_transfer;
    logic                w_fetch_en;
    logic                w_halt_word;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_transfer  = r_out_valid && out_ready;
    assign w_fetch_en  = (r_state == S_FETCH) && w_slot_free && !redirect;
    assign w_halt_word = (HALT_ON_ZERO != 0) && (instr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= L_RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_out_valid   <= w_valid_nxt;
            r_out_instr   <= w_instr_nxt;
            r_out_pc      <= w_out_pc_nxt;
            r_fetch_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_out_valid;
        w_instr_nxt  = r_out_instr;
        w_out_pc_nxt = r_out_pc;

        // A consumed word leaves the slot unless a new load replaces it below.
        if (w_transfer) begin
            w_valid_nxt = 1'b0;
        end

        if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_valid_nxt = 1'b0;
            if ((r_state != S_IDLE) || start) begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_fetch_en) begin
                        if (w_halt_word) begin
                            w_valid_nxt = 1'b0;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_instr_nxt  = instr;
                            w_out_pc_nxt = r_pc;
                            w_valid_nxt  = 1'b1;
                            w_pc_nxt     = r_pc + L_PC_ONE;
                        end
                    end
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_fetch_count;
        if (w_transfer && (r_fetch_count != 16'hFFFF)) begin
            w_count_nxt = r_fetch_count + 16'd1;
        end
    end

    assign instr_addr  = r_pc;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_valid   = r_out_valid;
    assign halted      = (r_state == S_HALT);
    assign busy        = (r_state == S_FETCH) || r_out_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (halt-on-zero on and off) share
// stimulus; directed scenarios plus a random run against a behavioural model.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        out_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] rom [256];

    logic [7:0]  instr_addr_a, out_pc_a, instr_addr_b, out_pc_b;
    logic [15:0] instr_a, out_instr_a, fetch_count_a;
    logic [15:0] instr_b, out_instr_b, fetch_count_b;
    logic        out_valid_a, halted_a, busy_a;
    logic        out_valid_b, halted_b, busy_b;

    assign instr_a = rom[instr_addr_a];
    assign instr_b = rom[instr_addr_b];

    instr_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0), .HALT_ON_ZERO(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .instr_addr(instr_addr_a), .instr(instr_a),
        .out_instr(out_instr_a), .out_pc(out_pc_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted_a), .busy(busy_a), .fetch_count(fetch_count_a)
    );

    instr_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0), .HALT_ON_ZERO(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .instr_addr(instr_addr_b), .instr(instr_b),
        .out_instr(out_instr_b), .out_pc(out_pc_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted_b), .busy(busy_b), .fetch_count(fetch_count_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  obs_addr [2];
    logic [7:0]  obs_pc   [2];
    logic [15:0] obs_instr[2];
    logic [15:0] obs_cnt  [2];
    logic        obs_valid[2];
    logic        obs_halt [2];
    logic        obs_busy [2];

    always_comb begin
        obs_addr[0]  = instr_addr_a;  obs_addr[1]  = instr_addr_b;
        obs_pc[0]    = out_pc_a;      obs_pc[1]    = out_pc_b;
        obs_instr[0] = out_instr_a;   obs_instr[1] = out_instr_b;
        obs_cnt[0]   = fetch_count_a; obs_cnt[1]   = fetch_count_b;
        obs_valid[0] = out_valid_a;   obs_valid[1] = out_valid_b;
        obs_halt[0]  = halted_a;      obs_halt[1]  = halted_b;
        obs_busy[0]  = busy_a;        obs_busy[1]  = busy_b;
    end

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode[2];
    logic [7:0]  m_pc  [2];
    bit          m_v   [2];
    logic [15:0] m_i   [2];
    logic [7:0]  m_p   [2];
    int          m_cnt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_pc[k] = 8'd0; m_v[k] = 1'b0;
            m_i[k] = 16'd0; m_p[k] = 8'd0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit halt_on_zero);
        logic [15:0] word;
        word = rom[m_pc[k]];
        if (m_v[k] && out_ready) begin
            m_v[k] = 1'b0;
            if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
        end
        if (redirect) begin
            m_pc[k] = redirect_pc;
            m_v[k]  = 1'b0;
            if (m_mode[k] != 0 || start) m_mode[k] = 1;
        end else if (m_mode[k] == 0) begin
            if (start) m_mode[k] = 1;
        end else if (m_mode[k] == 1 && !m_v[k]) begin
            if (halt_on_zero && word == 16'd0) begin
                m_mode[k] = 2;
            end else begin
                m_v[k] = 1'b1; m_i[k] = word; m_p[k] = m_pc[k];
                m_pc[k] = m_pc[k] + 8'd1;
            end
        end
    endtask

    task automatic tick();
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid_a); end
        vectors++; if (halted_a !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted_a); end
        vectors++; if (fetch_count_a !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count_a); end
        vectors++; if (instr_addr_a !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", instr_addr_a); end
        vectors++; if (out_pc_a !== 8'd0 || out_instr_a !== 16'd0) begin errors++; $display("FAIL reset_slot: got pc %0h instr %0h want 0 0", out_pc_a, out_instr_a); end
        tick();
        vectors++; if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL idle_quiet: got busy %0b valid %0b want 0 0", busy_a, out_valid_a); end
    endtask

    task automatic test_run_to_halt();
        int n;
        logic [7:0] exp_pc;
        for (int i = 0; i < 256; i++) rom[i] = (i < 14) ? 16'($urandom_range(1, 65535)) : 16'd0;
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (out_valid_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL start_latency: got valid %0b busy %0b want 0 1", out_valid_a, busy_a); end
        tick();
        vectors++; if (out_valid_a !== 1'b1 || out_pc_a !== 8'd0) begin errors++; $display("FAIL first_fetch: got valid %0b pc %0h want 1 0", out_valid_a, out_pc_a); end
        exp_pc = 8'd0; n = 0;
        while (!halted_a && n < 40) begin
            if (out_valid_a) begin
                vectors++;
                if (out_pc_a !== exp_pc || out_instr_a !== rom[exp_pc]) begin
                    errors++; $display("FAIL run_seq: got pc %0h instr %0h want pc %0h instr %0h", out_pc_a, out_instr_a, exp_pc, rom[exp_pc]);
                end
                exp_pc = exp_pc + 8'd1;
            end
            tick(); n++;
        end
        vectors++; if (halted_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL halt_state: got halted %0b valid %0b want 1 0", halted_a, out_valid_a); end
        vectors++; if (fetch_count_a !== 16'd14 || exp_pc !== 8'd14) begin errors++; $display("FAIL halt_count: got count %0d seen %0d want 14 14", fetch_count_a, exp_pc); end
        vectors++; if (instr_addr_a !== 8'd14) begin errors++; $display("FAIL halt_addr: got %0h want 0e", instr_addr_a); end
    endtask

    task automatic test_restart_from_halt();
        redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect = 1'b0;
        vectors++; if (halted_a !== 1'b0 || out_valid_a !== 1'b0 || instr_addr_a !== 8'h00) begin
            errors++; $display("FAIL restart_edge: got halted %0b valid %0b addr %0h want 0 0 00", halted_a, out_valid_a, instr_addr_a); end
        tick();
        vectors++; if (out_valid_a !== 1'b1 || out_pc_a !== 8'h00 || fetch_count_a !== 16'd14) begin
            errors++; $display("FAIL restart_first: got valid %0b pc %0h count %0d want 1 00 14", out_valid_a, out_pc_a, fetch_count_a); end
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] held;
        n = 0;
        while (!(out_valid_a && out_pc_a == 8'd3) && n < 10) begin tick(); n++; end
        vectors++; if (out_pc_a !== 8'd3 || out_valid_a !== 1'b1) begin errors++; $display("FAIL bp_reach: got pc %0h valid %0b want 03 1", out_pc_a, out_valid_a); end
        held = out_instr_a;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (out_pc_a !== 8'd3 || out_instr_a !== held || instr_addr_a !== 8'd4 || out_valid_a !== 1'b1) begin
                errors++; $display("FAIL bp_hold: got pc %0h instr %0h addr %0h valid %0b want 03 %0h 04 1", out_pc_a, out_instr_a, instr_addr_a, out_valid_a, held);
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_pc_a !== 8'd4 || out_instr_a !== rom[4]) begin errors++; $display("FAIL bp_resume4: got pc %0h want 04", out_pc_a); end
        tick();
        vectors++; if (out_pc_a !== 8'd5 || out_instr_a !== rom[5]) begin errors++; $display("FAIL bp_resume5: got pc %0h want 05", out_pc_a); end
        n = 0;
        while (!halted_a && n < 30) begin tick(); n++; end
        vectors++; if (halted_a !== 1'b1 || fetch_count_a !== 16'd28) begin errors++; $display("FAIL bp_total: got halted %0b count %0d want 1 28", halted_a, fetch_count_a); end
    endtask

    task automatic test_redirect_flush();
        int n;
        logic [15:0] c;
        redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect = 1'b0;
        n = 0;
        while (!(out_valid_a && out_pc_a == 8'd2) && n < 10) begin tick(); n++; end
        out_ready = 1'b0;
        tick();
        vectors++; if (out_pc_a !== 8'd2 || out_valid_a !== 1'b1) begin errors++; $display("FAIL flush_setup: got pc %0h valid %0b want 02 1", out_pc_a, out_valid_a); end
        c = fetch_count_a;
        redirect = 1'b1; redirect_pc = 8'h05;
        tick();
        redirect = 1'b0;
        vectors++; if (out_valid_a !== 1'b0 || fetch_count_a !== c) begin errors++; $display("FAIL flush_edge: got valid %0b count %0d want 0 %0d", out_valid_a, fetch_count_a, c); end
        tick();
        vectors++; if (out_valid_a !== 1'b1 || out_pc_a !== 8'h05 || out_instr_a !== rom[5] || fetch_count_a !== c) begin
            errors++; $display("FAIL flush_target: got valid %0b pc %0h count %0d want 1 05 %0d", out_valid_a, out_pc_a, fetch_count_a, c); end
        out_ready = 1'b1;
        n = 0;
        while (!halted_a && n < 30) begin tick(); n++; end
    endtask

    task automatic test_pc_wrap();
        logic [7:0] e;
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = 8'hFE + 8'(i);
            vectors++;
            if (out_valid_b !== 1'b1 || out_pc_b !== e || out_instr_b !== rom[e] || halted_b !== 1'b0) begin
                errors++; $display("FAIL wrap_seq: got valid %0b pc %0h instr %0h halted %0b want 1 %0h %0h 0", out_valid_b, out_pc_b, out_instr_b, halted_b, e, rom[e]);
            end
        end
        vectors++; if (halted_a !== 1'b1 || instr_addr_a !== 8'hFE) begin errors++; $display("FAIL wrap_halt_a: got halted %0b addr %0h want 1 fe", halted_a, instr_addr_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom_range(0, 255));
            start       = ($urandom_range(0, 29) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs_valid[k] !== m_v[k] || obs_pc[k] !== m_p[k] || obs_instr[k] !== m_i[k] ||
                    obs_addr[k] !== m_pc[k] || obs_cnt[k] !== 16'(m_cnt[k]) ||
                    obs_halt[k] !== (m_mode[k] == 2) || obs_busy[k] !== (m_mode[k] == 1 || m_v[k])) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got v%0b pc%0h i%0h a%0h c%0d h%0b b%0b want v%0b pc%0h i%0h a%0h c%0d mode%0d",
                             k, cyc, obs_valid[k], obs_pc[k], obs_instr[k], obs_addr[k], obs_cnt[k], obs_halt[k], obs_busy[k],
                             m_v[k], m_p[k], m_i[k], m_pc[k], m_cnt[k], m_mode[k]);
                end
            end
        end
        start = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 16; i < 32; i++) rom[i] = 16'($urandom_range(1, 65535));
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (out_valid_a !== 1'b0 || halted_a !== 1'b0 || fetch_count_a !== 16'd0 || out_pc_a !== 8'd0 || instr_addr_a !== 8'd0) begin
            errors++; $display("FAIL async_reset: got valid %0b halted %0b count %0d pc %0h addr %0h want all 0", out_valid_a, halted_a, fetch_count_a, out_pc_a, instr_addr_a); end
        vectors++; if (out_valid_b !== 1'b0 || fetch_count_b !== 16'd0) begin errors++; $display("FAIL async_reset_b: got valid %0b count %0d want 0 0", out_valid_b, fetch_count_b); end
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy %0b valid %0b want 0 0", busy_a, out_valid_a); end
    endtask

    task automatic test_redirect_with_transfer();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) rom[i] = 16'($urandom_range(1, 65535));
        for (int i = 32; i < 48; i++) rom[i] = 16'($urandom_range(1, 65535));
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++; if (out_valid_a !== 1'b1 || out_pc_a !== 8'd0) begin errors++; $display("FAIL rwt_setup: got valid %0b pc %0h want 1 00", out_valid_a, out_pc_a); end
        c = fetch_count_a;
        redirect = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        vectors++; if (fetch_count_a !== c + 16'd1 || out_valid_a !== 1'b0) begin
            errors++; $display("FAIL rwt_count: got count %0d valid %0b want %0d 0", fetch_count_a, out_valid_a, c + 16'd1); end
        tick();
        vectors++; if (out_valid_a !== 1'b1 || out_pc_a !== 8'h20 || fetch_count_a !== c + 16'd1) begin
            errors++; $display("FAIL rwt_target: got valid %0b pc %0h count %0d want 1 20 %0d", out_valid_a, out_pc_a, fetch_count_a, c + 16'd1); end
    endtask

    initial begin
        test_reset();
        test_run_to_halt();
        test_restart_from_halt();
        test_backpressure();
        test_redirect_flush();
        test_pc_wrap();
        test_random();
        test_async_reset();
        test_redirect_with_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
